// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two cache refill/writeback engines, the shared memory port and the arbiter.
// slave is the arbiter's view; master is the view of the caches and memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              ic_req_valid, ic_req_ready, ic_req_rw;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_data_valid, ic_data_ready;
  logic [DATA_W-1:0] ic_data_bits;
  logic [DATA_W/8-1:0] ic_data_mask;
  logic              ic_resp_valid;

  logic              dc_req_valid, dc_req_ready, dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_data_valid, dc_data_ready;
  logic [DATA_W-1:0] dc_data_bits;
  logic [DATA_W/8-1:0] dc_data_mask;
  logic              dc_resp_valid;

  logic [DATA_W-1:0] resp_data;

  logic              mem_req_valid, mem_req_ready, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_data_valid, mem_data_ready;
  logic [DATA_W-1:0] mem_data_bits;
  logic [DATA_W/8-1:0] mem_data_mask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport slave (
    input  ic_req_valid, ic_req_rw, ic_req_addr, ic_data_valid, ic_data_bits, ic_data_mask,
    output ic_req_ready, ic_data_ready, ic_resp_valid,
    input  dc_req_valid, dc_req_rw, dc_req_addr, dc_data_valid, dc_data_bits, dc_data_mask,
    output dc_req_ready, dc_data_ready, dc_resp_valid,
    output resp_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_data_valid, mem_data_bits, mem_data_mask,
    input  mem_req_ready, mem_data_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output ic_req_valid, ic_req_rw, ic_req_addr, ic_data_valid, ic_data_bits, ic_data_mask,
    input  ic_req_ready, ic_data_ready, ic_resp_valid,
    output dc_req_valid, dc_req_rw, dc_req_addr, dc_data_valid, dc_data_bits, dc_data_mask,
    input  dc_req_ready, dc_data_ready, dc_resp_valid,
    input  resp_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_data_valid, mem_data_bits, mem_data_mask,
    output mem_req_ready, mem_data_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between icache and dcache: one line transaction at a time,
// round-robin grant on conflict, channels forwarded to the current owner until the last beat.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                owner,
  output logic                busy,
  output logic                protocol_err
);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

  state_t             state;
  logic               last_owner;
  logic [CNT_W-1:0]   beat_cnt;

  logic                sel_req_valid, sel_req_rw, sel_data_valid;
  logic [ADDR_W-1:0]   sel_req_addr;
  logic [DATA_W-1:0]   sel_data_bits;
  logic [DATA_W/8-1:0] sel_data_mask;
  logic                in_req, in_wdata, in_rdata, data_hs;

  always_comb begin
    sel_req_valid  = owner ? bus.dc_req_valid  : bus.ic_req_valid;
    sel_req_rw     = owner ? bus.dc_req_rw     : bus.ic_req_rw;
    sel_req_addr   = owner ? bus.dc_req_addr   : bus.ic_req_addr;
    sel_data_valid = owner ? bus.dc_data_valid : bus.ic_data_valid;
    sel_data_bits  = owner ? bus.dc_data_bits  : bus.ic_data_bits;
    sel_data_mask  = owner ? bus.dc_data_mask  : bus.ic_data_mask;
  end

  assign in_req   = (state == REQ);
  assign in_wdata = (state == WDATA);
  assign in_rdata = (state == RDATA);
  assign data_hs  = in_wdata & sel_data_valid & bus.mem_data_ready;

  assign bus.mem_req_valid  = in_req & sel_req_valid;
  assign bus.mem_req_rw     = sel_req_rw;
  assign bus.mem_req_addr   = sel_req_addr;
  assign bus.mem_data_valid = in_wdata & sel_data_valid;
  assign bus.mem_data_bits  = sel_data_bits;
  assign bus.mem_data_mask  = sel_data_mask;

  // Non-owner handshakes are held low in every state.
  assign bus.ic_req_ready  = in_req   & ~owner & bus.mem_req_ready;
  assign bus.dc_req_ready  = in_req   &  owner & bus.mem_req_ready;
  assign bus.ic_data_ready = in_wdata & ~owner & bus.mem_data_ready;
  assign bus.dc_data_ready = in_wdata &  owner & bus.mem_data_ready;
  assign bus.ic_resp_valid = in_rdata & ~owner & bus.mem_resp_valid;
  assign bus.dc_resp_valid = in_rdata &  owner & bus.mem_resp_valid;
  assign bus.resp_data     = bus.mem_resp_data;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_owner   <= 1'b0;
      beat_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (bus.mem_resp_valid && !in_rdata) protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.ic_req_valid || bus.dc_req_valid) begin
            owner <= (bus.ic_req_valid && bus.dc_req_valid) ? ~last_owner : bus.dc_req_valid;
            state <= REQ;
          end
        end
        REQ: begin
          if (!sel_req_valid) begin
            state <= IDLE;
          end else if (bus.mem_req_ready) begin
            last_owner <= owner;
            beat_cnt   <= '0;
            state      <= sel_req_rw ? WDATA : RDATA;
          end
        end
        WDATA, RDATA: begin
          if (in_wdata ? data_hs : bus.mem_resp_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic, every cycle
// compared against a transaction-level model of the arbitration and forwarding rules.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int BEATS  = 4;
  localparam int MW     = DATA_W / 8;

  logic clk, reset;
  logic owner, busy, protocol_err;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .owner(owner), .busy(busy), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: is a transaction open, has memory accepted it, who owns it, beats done.
  bit m_busy = 0, m_acc = 0, m_owner = 0, m_last = 0, m_rw = 0, m_perr = 0;
  int m_beat = 0;
  int grants[$];
  logic [DATA_W-1:0] wr_seen[$];

  bit v[2], rwi[2], dv[2];
  bit e_mreq, e_mdat;
  bit e_rrdy[2], e_drdy[2], e_resp[2];

  // Randomized cache agents and memory
  bit rnd = 0;
  bit a_act[2], a_gnt[2], a_rw[2], a_dv[2];
  int a_beat[2];
  logic [ADDR_W-1:0] a_addr[2];
  logic [DATA_W-1:0] a_data[2][BEATS];
  logic [MW-1:0]     a_mask[2][BEATS];
  int mem_owe = 0;

  function automatic logic [DATA_W-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic eval_and_check();
    logic [9:0] exp_ctrl, got_ctrl;
    v[0] = bus.ic_req_valid;  v[1] = bus.dc_req_valid;
    rwi[0] = bus.ic_req_rw;   rwi[1] = bus.dc_req_rw;
    dv[0] = bus.ic_data_valid; dv[1] = bus.dc_data_valid;
    e_mreq = m_busy && !m_acc && v[m_owner];
    e_mdat = m_busy && m_acc && m_rw && dv[m_owner];
    for (int s = 0; s < 2; s++) begin
      e_rrdy[s] = m_busy && !m_acc && (m_owner == s[0]) && bus.mem_req_ready;
      e_drdy[s] = m_busy && m_acc && m_rw && (m_owner == s[0]) && bus.mem_data_ready;
      e_resp[s] = m_busy && m_acc && !m_rw && (m_owner == s[0]) && bus.mem_resp_valid;
    end
    exp_ctrl = {m_busy, e_mreq, e_mdat, e_rrdy[0], e_rrdy[1], e_drdy[0], e_drdy[1],
                e_resp[0], e_resp[1], m_perr};
    got_ctrl = {busy, bus.mem_req_valid, bus.mem_data_valid, bus.ic_req_ready, bus.dc_req_ready,
                bus.ic_data_ready, bus.dc_data_ready, bus.ic_resp_valid, bus.dc_resp_valid,
                protocol_err};
    check_val("ctrl", got_ctrl, exp_ctrl);
    if (m_busy) check_val("owner", owner, m_owner);
    if (e_mreq)
      check_val("req_fwd", {bus.mem_req_rw, bus.mem_req_addr},
                m_owner ? {bus.dc_req_rw, bus.dc_req_addr} : {bus.ic_req_rw, bus.ic_req_addr});
    if (e_mdat) begin
      check_val("wbits", bus.mem_data_bits, m_owner ? bus.dc_data_bits : bus.ic_data_bits);
      check_val("wmask", bus.mem_data_mask, m_owner ? bus.dc_data_mask : bus.ic_data_mask);
      if (bus.mem_data_ready) wr_seen.push_back(bus.mem_data_bits);
    end
    if (e_resp[0] || e_resp[1]) check_val("rdata", bus.resp_data, bus.mem_resp_data);
  endtask

  task automatic model_update();
    if (reset) begin
      m_busy = 0; m_acc = 0; m_owner = 0; m_last = 0; m_rw = 0; m_perr = 0; m_beat = 0;
    end else begin
      if (bus.mem_resp_valid && !(m_busy && m_acc && !m_rw)) m_perr = 1;
      if (!m_busy) begin
        if (v[0] || v[1]) begin
          m_busy = 1; m_acc = 0;
          m_owner = (v[0] && v[1]) ? !m_last : v[1];
        end
      end else if (!m_acc) begin
        if (!v[m_owner]) m_busy = 0;
        else if (bus.mem_req_ready) begin
          m_acc = 1; m_last = m_owner; m_beat = 0; m_rw = rwi[m_owner];
          grants.push_back(int'(m_owner));
        end
      end else if (m_rw ? (dv[m_owner] && bus.mem_data_ready) : bus.mem_resp_valid) begin
        if (m_beat == BEATS - 1) m_busy = 0;
        else m_beat++;
      end
    end
  endtask

  task automatic agents_update();
    if (e_mreq && bus.mem_req_ready && !rwi[m_owner]) mem_owe = BEATS;
    if (bus.mem_resp_valid && mem_owe > 0) mem_owe--;
    for (int s = 0; s < 2; s++) begin
      if (a_act[s]) begin
        if (!a_gnt[s]) begin
          if (e_rrdy[s] && v[s]) begin a_gnt[s] = 1; a_beat[s] = 0; end
        end else if (a_rw[s] ? (e_drdy[s] && a_dv[s]) : e_resp[s]) begin
          a_beat[s]++;
          if (a_beat[s] == BEATS) a_act[s] = 0;
        end
      end else if ($urandom_range(2) == 0) begin
        a_act[s] = 1; a_gnt[s] = 0; a_beat[s] = 0;
        a_rw[s] = 1'($urandom); a_addr[s] = ADDR_W'($urandom);
        for (int b = 0; b < BEATS; b++) begin
          a_data[s][b] = rnd_beat();
          a_mask[s][b] = MW'($urandom);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    eval_and_check();
    if (rnd) agents_update();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ic_req_valid = 0; bus.ic_req_rw = 0; bus.ic_req_addr = '0;
    bus.ic_data_valid = 0; bus.ic_data_bits = '0; bus.ic_data_mask = '0;
    bus.dc_req_valid = 0; bus.dc_req_rw = 0; bus.dc_req_addr = '0;
    bus.dc_data_valid = 0; bus.dc_data_bits = '0; bus.dc_data_mask = '0;
    bus.mem_req_ready = 0; bus.mem_data_ready = 0; bus.mem_resp_valid = 0;
    bus.mem_resp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
    for (int s = 0; s < 2; s++) begin a_act[s] = 0; a_gnt[s] = 0; a_dv[s] = 0; a_beat[s] = 0; end
    mem_owe = 0;
  endtask

  task automatic drive_random();
    int b0, b1;
    b0 = (a_beat[0] < BEATS) ? a_beat[0] : 0;
    b1 = (a_beat[1] < BEATS) ? a_beat[1] : 0;
    a_dv[0] = a_act[0] && a_gnt[0] && a_rw[0] && ($urandom_range(3) != 0);
    a_dv[1] = a_act[1] && a_gnt[1] && a_rw[1] && ($urandom_range(3) != 0);
    bus.ic_req_valid = a_act[0] && !a_gnt[0]; bus.ic_req_rw = a_rw[0]; bus.ic_req_addr = a_addr[0];
    bus.ic_data_valid = a_dv[0]; bus.ic_data_bits = a_data[0][b0]; bus.ic_data_mask = a_mask[0][b0];
    bus.dc_req_valid = a_act[1] && !a_gnt[1]; bus.dc_req_rw = a_rw[1]; bus.dc_req_addr = a_addr[1];
    bus.dc_data_valid = a_dv[1]; bus.dc_data_bits = a_data[1][b1]; bus.dc_data_mask = a_mask[1][b1];
    bus.mem_req_ready  = 1'($urandom);
    bus.mem_data_ready = 1'($urandom);
    bus.mem_resp_valid = (mem_owe > 0) && ($urandom_range(1) == 1);
    bus.mem_resp_data  = rnd_beat();
  endtask

  initial begin
    logic [DATA_W-1:0] d[BEATS];
    int wb, n0;
    bit started;

    reset = 1;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();
    check_val("rst_busy", busy, 0);
    check_val("rst_owner", owner, 0);
    check_val("rst_perr", protocol_err, 0);

    // Lone icache read
    for (int i = 0; i < BEATS; i++) d[i] = rnd_beat();
    bus.ic_req_valid = 1; bus.ic_req_rw = 0; bus.ic_req_addr = 28'h0000123;
    tick();
    check_val("t1_req_valid", bus.mem_req_valid, 1);
    check_val("t1_req_addr", bus.mem_req_addr, 28'h0000123);
    bus.mem_req_ready = 1;
    tick();
    bus.ic_req_valid = 0; bus.mem_req_ready = 0;
    for (int i = 0; i < BEATS; i++) begin
      bus.mem_resp_valid = 1; bus.mem_resp_data = d[i];
      #1;
      check_val("t1_ic_resp", bus.ic_resp_valid, 1);
      check_val("t1_dc_resp", bus.dc_resp_valid, 0);
      check_val("t1_data", bus.resp_data, d[i]);
      tick();
    end
    bus.mem_resp_valid = 0;
    check_val("t1_busy_end", busy, 0);

    // Both read continuously: grants alternate starting with dcache
    do_reset();
    grants.delete();
    bus.ic_req_valid = 1; bus.dc_req_valid = 1; bus.mem_req_ready = 1;
    for (int c = 0; c < 200 && grants.size() < 4; c++) begin
      bus.mem_resp_valid = m_busy && m_acc && !m_rw;
      bus.mem_resp_data = rnd_beat();
      tick();
    end
    check_val("t2_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      check_val("t2_grant_order", grants[i], (i % 2 == 0) ? 1 : 0);
    bus.ic_req_valid = 0; bus.dc_req_valid = 0;
    for (int c = 0; c < 40 && m_busy; c++) begin
      bus.mem_resp_valid = m_busy && m_acc && !m_rw;
      tick();
    end
    bus.mem_resp_valid = 0;

    // dcache write-back with memory data-ready toggling
    do_reset();
    wr_seen.delete();
    for (int i = 0; i < BEATS; i++) d[i] = rnd_beat();
    bus.dc_req_valid = 1; bus.dc_req_rw = 1; bus.dc_req_addr = 28'h0ABCDEF;
    bus.dc_data_mask = '1; bus.mem_req_ready = 1;
    wb = 0; started = 0;
    for (int c = 0; c < 60; c++) begin
      bus.dc_data_valid = (wb < BEATS);
      bus.dc_data_bits  = d[(wb < BEATS) ? wb : 0];
      bus.mem_data_ready = (c % 2 == 1);
      tick();
      if (e_drdy[1] && bus.dc_data_valid) wb++;
      if (m_acc) begin bus.dc_req_valid = 0; started = 1; end
      if (started && !m_busy) break;
    end
    check_val("t3_beats", wb, BEATS);
    check_val("t3_fwd_count", wr_seen.size(), BEATS);
    for (int i = 0; i < wr_seen.size() && i < BEATS; i++) check_val("t3_fwd_order", wr_seen[i], d[i]);
    check_val("t3_busy_end", busy, 0);
    bus.dc_data_valid = 0; bus.mem_data_ready = 0;

    // Memory stalls the request; icache gives up
    do_reset();
    n0 = grants.size();
    bus.ic_req_valid = 1; bus.ic_req_rw = 0; bus.ic_req_addr = 28'h0555AAA;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) bus.ic_req_valid = 0;
      tick();
    end
    check_val("t4_busy", busy, 0);
    check_val("t4_no_txn", grants.size(), n0);
    check_val("t4_perr", protocol_err, 0);

    // Stray response beat in IDLE
    bus.mem_resp_valid = 1; bus.mem_resp_data = rnd_beat();
    tick();
    bus.mem_resp_valid = 0;
    tick(); tick();
    check_val("t5_perr_sticky", protocol_err, 1);

    // Reset in the middle of a read, then a clean read
    do_reset();
    bus.ic_req_valid = 1; bus.ic_req_addr = 28'h0000777; bus.mem_req_ready = 1;
    tick(); tick();
    bus.ic_req_valid = 0; bus.mem_req_ready = 0; bus.mem_resp_valid = 1;
    tick(); tick();
    reset = 1; bus.mem_resp_valid = 0;
    tick();
    reset = 0;
    check_val("t6_busy", busy, 0);
    check_val("t6_perr", protocol_err, 0);
    check_val("t6_mem_req", bus.mem_req_valid, 0);
    bus.ic_req_valid = 1; bus.mem_req_ready = 1;
    tick(); tick();
    bus.ic_req_valid = 0; bus.mem_req_ready = 0;
    for (int i = 0; i < BEATS; i++) begin
      bus.mem_resp_valid = 1; bus.mem_resp_data = rnd_beat();
      tick();
    end
    bus.mem_resp_valid = 0;
    check_val("t6_done", busy, 0);
    check_val("t6_perr_clean", protocol_err, 0);

    // Randomized traffic from both caches
    do_reset();
    rnd = 1;
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      tick();
    end
    check_val("rnd_perr", protocol_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
